mem_stage: RTL and testbench

- Memory/writeback stage directly downstream of the ALU.
- Consumes ALU result, store data, write flag and new SP value.
- For LD/ST/PUSH/POP it runs one bus transaction with wait states and a timeout; for all other ops it passes the ALU result through to register writeback.
- Drives the register-file write port and the SP update.
- Asserts busy so control holds the pipeline while a transaction is open.

---
 rtl/mem_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : Memory/writeback stage. Runs one bus transaction with a
//               timeout for LD/ST/PUSH/POP and passes other ALU results
//               straight through to register and SP writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  mem_op,
    input  logic        byte_op,
    input  logic        write,
    input  logic [2:0]  rD_sel,
    input  logic [15:0] alu_out,
    input  logic [15:0] mem_data,
    input  logic        sp_update,
    input  logic [15:0] SP_in,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic [1:0]  bus_be,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        rD_write,
    output logic [2:0]  rD_write_sel,
    output logic [15:0] rD_write_data,
    output logic        SP_write,
    output logic [15:0] SP_write_data
);

    localparam logic [1:0] c_OP_LOAD  = 2'd1;
    localparam logic [1:0] c_OP_STORE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      r_state;
    logic [TO_W-1:0] r_cnt;

    logic        r_is_load;
    logic        r_byte;
    logic        r_write;
    logic [2:0]  r_sel;
    logic [15:0] r_alu;
    logic        r_sp_upd;
    logic [15:0] r_sp;

    logic            w_is_mem;
    logic            w_misaligned;
    logic [TO_W-1:0] w_cnt_nxt;
    logic            w_expired;
    logic [15:0]     w_load_val;

    always_comb begin
        w_is_mem     = (mem_op == c_OP_LOAD) || (mem_op == c_OP_STORE);
        w_misaligned = w_is_mem && !byte_op && alu_out[0];
        w_cnt_nxt    = r_cnt + 1'b1;
        w_expired    = (w_cnt_nxt == TO_W'(TIMEOUT));
        // Little-endian byte lanes: odd address selects the upper byte.
        if (r_byte)
            w_load_val = {8'h00, r_alu[0] ? bus_rdata[15:8] : bus_rdata[7:0]};
        else
            w_load_val = bus_rdata;
    end

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_is_load     <= 1'b0;
            r_byte        <= 1'b0;
            r_write       <= 1'b0;
            r_sel         <= 3'd0;
            r_alu         <= 16'h0000;
            r_sp_upd      <= 1'b0;
            r_sp          <= 16'h0000;
            done          <= 1'b0;
            fault         <= 1'b0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= 16'h0000;
            bus_wdata     <= 16'h0000;
            bus_be        <= 2'b00;
            rD_write      <= 1'b0;
            rD_write_sel  <= 3'd0;
            rD_write_data <= 16'h0000;
            SP_write      <= 1'b0;
            SP_write_data <= 16'h0000;
        end else begin
            done     <= 1'b0;
            fault    <= 1'b0;
            rD_write <= 1'b0;
            SP_write <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_is_load <= (mem_op == c_OP_LOAD);
                        r_byte    <= byte_op;
                        r_write   <= write;
                        r_sel     <= rD_sel;
                        r_alu     <= alu_out;
                        r_sp_upd  <= sp_update;
                        r_sp      <= SP_in;
                        if (!w_is_mem || w_misaligned) begin
                            r_state       <= FIN;
                            done          <= 1'b1;
                            fault         <= w_misaligned;
                            rD_write      <= write & ~w_misaligned;
                            rD_write_sel  <= rD_sel;
                            rD_write_data <= alu_out;
                            SP_write      <= sp_update & ~w_misaligned;
                            SP_write_data <= SP_in;
                        end else begin
                            r_state   <= BUS;
                            r_cnt     <= '0;
                            bus_req   <= 1'b1;
                            bus_we    <= (mem_op == c_OP_STORE);
                            bus_addr  <= alu_out;
                            if (byte_op) begin
                                bus_be    <= alu_out[0] ? 2'b10 : 2'b01;
                                bus_wdata <= {mem_data[7:0], mem_data[7:0]};
                            end else begin
                                bus_be    <= 2'b11;
                                bus_wdata <= mem_data;
                            end
                        end
                    end
                end

                BUS: begin
                    // An ack in the expiry cycle still completes normally.
                    if (bus_ack) begin
                        r_state       <= FIN;
                        bus_req       <= 1'b0;
                        bus_we        <= 1'b0;
                        done          <= 1'b1;
                        rD_write      <= r_write;
                        rD_write_sel  <= r_sel;
                        rD_write_data <= r_is_load ? w_load_val : r_alu;
                        SP_write      <= r_sp_upd;
                        SP_write_data <= r_sp;
                    end else if (w_expired) begin
                        r_state       <= FIN;
                        r_cnt         <= w_cnt_nxt;
                        bus_req       <= 1'b0;
                        bus_we        <= 1'b0;
                        done          <= 1'b1;
                        fault         <= 1'b1;
                        rD_write_sel  <= r_sel;
                        rD_write_data <= r_alu;
                        SP_write_data <= r_sp;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end

                FIN: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Control must never present a new op while the stage is occupied.
    a_no_en_while_busy : assert property (@(posedge clk) disable iff (!rst_n) !(en && busy));

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage (TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mem_op;
    logic        byte_op;
    logic        write;
    logic [2:0]  rD_sel;
    logic [15:0] alu_out;
    logic [15:0] mem_data;
    logic        sp_update;
    logic [15:0] SP_in;
    logic        busy;
    logic        done;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [1:0]  bus_be;
    logic        bus_ack;
    logic [15:0] bus_rdata;
    logic        rD_write;
    logic [2:0]  rD_write_sel;
    logic [15:0] rD_write_data;
    logic        SP_write;
    logic [15:0] SP_write_data;

    int errors = 0;
    int checks = 0;

    mem_stage #(.TIMEOUT(4), .TO_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .mem_op        (mem_op),
        .byte_op       (byte_op),
        .write         (write),
        .rD_sel        (rD_sel),
        .alu_out       (alu_out),
        .mem_data      (mem_data),
        .sp_update     (sp_update),
        .SP_in         (SP_in),
        .busy          (busy),
        .done          (done),
        .fault         (fault),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_be        (bus_be),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .rD_write      (rD_write),
        .rD_write_sel  (rD_write_sel),
        .rD_write_data (rD_write_data),
        .SP_write      (SP_write),
        .SP_write_data (SP_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic bop, input logic wr,
                         input logic [2:0] sel, input logic [15:0] addr,
                         input logic [15:0] wd, input logic spu, input logic [15:0] sp);
        en = 1'b1; mem_op = op; byte_op = bop; write = wr; rD_sel = sel;
        alu_out = addr; mem_data = wd; sp_update = spu; SP_in = sp;
        tick();
        en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mem_op = 2'd0; byte_op = 1'b0; write = 1'b0;
        rD_sel = 3'd0; alu_out = 16'h0; mem_data = 16'h0; sp_update = 1'b0;
        SP_in = 16'h0; bus_ack = 1'b0; bus_rdata = 16'h0;
        tick(); tick();
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_req", 16'(bus_req), 16'h0);
        check("rst_rdw", 16'(rD_write), 16'h0);
        check("rst_spw", 16'(SP_write), 16'h0);
        check("rst_addr", bus_addr, 16'h0);
        rst_n = 1'b1;
        tick();

        // ADD pass-through
        issue(2'd0, 1'b0, 1'b1, 3'd3, 16'h1234, 16'h0, 1'b0, 16'h0);
        check("add_done", 16'(done), 16'h1);
        check("add_fault", 16'(fault), 16'h0);
        check("add_rdw", 16'(rD_write), 16'h1);
        check("add_sel", 16'(rD_write_sel), 16'h3);
        check("add_data", rD_write_data, 16'h1234);
        check("add_req", 16'(bus_req), 16'h0);
        tick();
        check("add_done_pulse", 16'(done), 16'h0);
        check("add_idle", 16'(busy), 16'h0);

        // Word load, two wait states
        issue(2'd1, 1'b0, 1'b1, 3'd5, 16'h0040, 16'h0, 1'b0, 16'h0);
        check("wld_req1", 16'(bus_req), 16'h1);
        check("wld_we", 16'(bus_we), 16'h0);
        check("wld_be", 16'(bus_be), 16'h3);
        check("wld_addr", bus_addr, 16'h0040);
        check("wld_busy", 16'(busy), 16'h1);
        tick();
        check("wld_req2", 16'(bus_req), 16'h1);
        tick();
        check("wld_req3", 16'(bus_req), 16'h1);
        check("wld_addr3", bus_addr, 16'h0040);
        bus_ack = 1'b1; bus_rdata = 16'hBEEF;
        tick();
        bus_ack = 1'b0;
        check("wld_req_off", 16'(bus_req), 16'h0);
        check("wld_done", 16'(done), 16'h1);
        check("wld_rdw", 16'(rD_write), 16'h1);
        check("wld_sel", 16'(rD_write_sel), 16'h5);
        check("wld_data", rD_write_data, 16'hBEEF);
        tick();

        // PUSH byte store at odd address
        issue(2'd2, 1'b1, 1'b0, 3'd0, 16'h0101, 16'h00A5, 1'b1, 16'h0FFE);
        check("push_be", 16'(bus_be), 16'h2);
        check("push_wdata", bus_wdata, 16'hA5A5);
        check("push_we", 16'(bus_we), 16'h1);
        check("push_addr", bus_addr, 16'h0101);
        bus_ack = 1'b1; bus_rdata = 16'h5555;
        tick();
        bus_ack = 1'b0;
        check("push_done", 16'(done), 16'h1);
        check("push_spw", 16'(SP_write), 16'h1);
        check("push_spd", SP_write_data, 16'h0FFE);
        check("push_rdw", 16'(rD_write), 16'h0);
        check("push_we_off", 16'(bus_we), 16'h0);
        tick();

        // Misaligned word load
        issue(2'd1, 1'b0, 1'b1, 3'd2, 16'h0003, 16'h0, 1'b0, 16'h0);
        check("mis_req", 16'(bus_req), 16'h0);
        check("mis_done", 16'(done), 16'h1);
        check("mis_fault", 16'(fault), 16'h1);
        check("mis_rdw", 16'(rD_write), 16'h0);
        tick();
        check("mis_fault_pulse", 16'(fault), 16'h0);

        // Timeout: no ack for four request cycles
        issue(2'd1, 1'b0, 1'b1, 3'd1, 16'h0080, 16'h0, 1'b1, 16'h1111);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("to_req%0d", i), 16'(bus_req), 16'h1);
            check($sformatf("to_nodone%0d", i), 16'(done), 16'h0);
            tick();
        end
        check("to_req_off", 16'(bus_req), 16'h0);
        check("to_done", 16'(done), 16'h1);
        check("to_fault", 16'(fault), 16'h1);
        check("to_rdw", 16'(rD_write), 16'h0);
        check("to_spw", 16'(SP_write), 16'h0);
        tick();

        // Ack in the expiry cycle wins; byte load from odd address
        issue(2'd1, 1'b1, 1'b1, 3'd6, 16'h0081, 16'h0, 1'b0, 16'h0);
        tick(); tick(); tick();
        check("late_req4", 16'(bus_req), 16'h1);
        check("late_be", 16'(bus_be), 16'h2);
        bus_ack = 1'b1; bus_rdata = 16'hC37A;
        tick();
        bus_ack = 1'b0;
        check("late_done", 16'(done), 16'h1);
        check("late_fault", 16'(fault), 16'h0);
        check("late_rdw", 16'(rD_write), 16'h1);
        check("late_data", rD_write_data, 16'h00C3);
        tick();

        // Zero-wait byte load from even address
        issue(2'd1, 1'b1, 1'b1, 3'd7, 16'h0082, 16'h0, 1'b0, 16'h0);
        check("bld_be", 16'(bus_be), 16'h1);
        check("bld_nodone", 16'(done), 16'h0);
        bus_ack = 1'b1; bus_rdata = 16'hC37A;
        tick();
        bus_ack = 1'b0;
        check("bld_done", 16'(done), 16'h1);
        check("bld_data", rD_write_data, 16'h007A);
        check("bld_sel", 16'(rD_write_sel), 16'h7);
        tick();

        // Reset in the middle of a bus cycle
        issue(2'd2, 1'b0, 1'b1, 3'd4, 16'h0010, 16'h4321, 1'b1, 16'h2222);
        check("rstm_req", 16'(bus_req), 16'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstm_req_off", 16'(bus_req), 16'h0);
        check("rstm_busy", 16'(busy), 16'h0);
        check("rstm_done", 16'(done), 16'h0);
        check("rstm_we", 16'(bus_we), 16'h0);
        bus_ack = 1'b1; bus_rdata = 16'h9999;
        tick();
        bus_ack = 1'b0;
        check("rstm_ack_rdw", 16'(rD_write), 16'h0);
        check("rstm_ack_spw", 16'(SP_write), 16'h0);
        check("rstm_ack_done", 16'(done), 16'h0);
        check("rstm_ack_busy", 16'(busy), 16'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
